// File: rtl/linecard_cfg_apb_arbiter.sv
// linecard_cfg_apb_arbiter
// Shares one APB completer port between NUM_REQ configuration requesters.
// A round-robin arbiter picks one requester per transaction, the FSM runs a
// full APB SETUP/ACCESS cycle, and a single-cycle response is returned to the
// granted requester.
// Optional build macro: LINECARD_CFG_ARB_TIMEOUT_EN adds an ACCESS-phase
// wait-state limit (TIMEOUT cycles) that ends a stalled transfer with an error.
//
// Request handshake (valid/ready): requester i raises req_valid[i] and holds
// req_write/req_addr/req_wdata stable until it sees req_ready[i]=1 in the same
// cycle; the request is accepted on that rising pclk edge. req_ready is
// combinational, one-hot, and only ever asserted in IDLE to the arbitration
// winner. The response is a one-cycle resp_valid[i] pulse; resp_rdata and
// resp_err are shared and only meaningful while resp_valid is non-zero.
module linecard_cfg_apb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [31:0]                   resp_rdata,
  output logic                          resp_err,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [31:0]                   pwdata,
  input  logic                          pready,
  input  logic [31:0]                   prdata,
  input  logic                          pslverr,
  output logic [1:0]                    dbg_state
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  logic [ID_W:0]   scan_sum;
  logic            grant;
  logic            win_write;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [31:0]     win_wdata;
  logic [ID_W-1:0] next_ptr;

`ifdef LINECARD_CFG_ARB_TIMEOUT_EN
  localparam int CLOG_TO = $clog2(TIMEOUT + 1);
  localparam int WAIT_W  = (CLOG_TO < 8) ? 8 : ((CLOG_TO > 16) ? 16 : CLOG_TO);
  logic [WAIT_W-1:0] wait_cnt;
`endif

  assign dbg_state = state;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_sum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[scan_sum[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_sum[ID_W-1:0];
      end
    end
  end

  // A grant only happens in IDLE and never while reset is being applied,
  // so a requester is never told it was accepted when the edge will discard it.
  assign grant = (state == IDLE) && win_found && !preset;

  // One-hot ready to the winner only.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win_id] = 1'b1;
    end
  end

  // Select the winner's request fields.
  always_comb begin
    win_write = req_write[win_id];
    win_addr  = req_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
    win_wdata = req_wdata[int'(win_id)*32 +: 32];
  end

  // Pointer moves to the requester just after the one that was served.
  assign next_ptr = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;

  // Transaction FSM with all APB and response outputs registered.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
`ifdef LINECARD_CFG_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            cur_id <= win_id;
            pwrite <= win_write;
            paddr  <= win_addr;
            pwdata <= win_write ? win_wdata : 32'h0;
            if (win_addr[1:0] != 2'b00) begin
              // Misaligned: answer with an error without touching the bus.
              state              <= RESP;
              resp_valid[win_id] <= 1'b1;
              resp_err           <= 1'b1;
              resp_rdata         <= 32'h0;
            end else begin
              state <= SETUP;
              psel  <= 1'b1;
            end
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef LINECARD_CFG_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        ACCESS: begin
          if (pready) begin
            state              <= RESP;
            psel               <= 1'b0;
            penable            <= 1'b0;
            resp_valid[cur_id] <= 1'b1;
            resp_rdata         <= pwrite ? 32'h0 : prdata;
            resp_err           <= pslverr;
          end
`ifdef LINECARD_CFG_ARB_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th wait cycle: abandon the transfer.
            state              <= RESP;
            psel               <= 1'b0;
            penable            <= 1'b0;
            resp_valid[cur_id] <= 1'b1;
            resp_rdata         <= 32'h0;
            resp_err           <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          state      <= IDLE;
          rr_ptr     <= next_ptr;
          resp_valid <= '0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_linecard_cfg_apb_arbiter.sv
// Testbench for linecard_cfg_apb_arbiter (NUM_REQ=4, ADDR_WIDTH=10).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge (or 1 time unit after it for the combinational req_ready).
// The timeout scenario is compiled only with LINECARD_CFG_ARB_TIMEOUT_EN.
module tb_linecard_cfg_apb_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;

  // ---------------- clock / reset / DUT ----------------
  logic              pclk = 1'b0;
  logic              preset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*32-1:0]   req_wdata;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [31:0]       pwdata;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;
  logic [1:0]        dbg_state;

  logic              stall;
  logic [31:0]       mem [0:255];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0] exp_q[$];

  always #5 pclk = ~pclk;

  linecard_cfg_apb_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (8)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr),
    .dbg_state  (dbg_state)
  );

  // APB completer model: word memory below 0x300, error region at and above.
  assign pready  = psel & penable & ~stall;
  assign pslverr = psel & penable & (paddr >= 10'h300);
  assign prdata  = (psel && penable && !pwrite && paddr < 10'h300) ? mem[paddr[9:2]] : 32'h0;

  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite && paddr < 10'h300) begin
      mem[paddr[9:2]] <= pwdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    stall     = 1'b0;
    preset    = 1'b1;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
  endtask

  task automatic set_req(input int id, input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    req_write[id]          = wr;
    req_addr[id*AW +: AW]  = a;
    req_wdata[id*32 +: 32] = d;
    req_valid[id]          = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    tests_run++; if ({psel, penable, pwrite} !== 3'b000) begin tests_failed++; $display("FAIL rst_apb_ctl: got %b want 000", {psel, penable, pwrite}); end
    tests_run++; if (paddr !== 10'h0 || pwdata !== 32'h0) begin tests_failed++; $display("FAIL rst_apb_data: got %h/%h want 0/0", paddr, pwdata); end
    tests_run++; if (resp_valid !== 4'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin tests_failed++; $display("FAIL rst_resp: got %b/%h/%b want 0/0/0", resp_valid, resp_rdata, resp_err); end
    tests_run++; if (req_ready !== 4'b0) begin tests_failed++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_write_read();
    // Write 0xC000_0123 to 0x000 from requester 1.
    @(negedge pclk); set_req(1, 1'b1, 10'h000, 32'hC000_0123); #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL wr_ready: got %b want 0010", req_ready); end
    @(negedge pclk); req_valid[1] = 1'b0;
    tests_run++; if ({psel, penable} !== 2'b10) begin tests_failed++; $display("FAIL wr_setup: got %b want 10", {psel, penable}); end
    tests_run++; if (paddr !== 10'h000 || pwrite !== 1'b1 || pwdata !== 32'hC000_0123) begin tests_failed++; $display("FAIL wr_setup_fields: got %h/%b/%h want 000/1/c0000123", paddr, pwrite, pwdata); end
    @(negedge pclk);
    tests_run++; if ({psel, penable} !== 2'b11) begin tests_failed++; $display("FAIL wr_access: got %b want 11", {psel, penable}); end
    @(negedge pclk);
    tests_run++; if (resp_valid !== 4'b0010 || resp_err !== 1'b0) begin tests_failed++; $display("FAIL wr_resp: got %b/%b want 0010/0", resp_valid, resp_err); end
    tests_run++; if (psel !== 1'b0) begin tests_failed++; $display("FAIL wr_resp_psel: got %b want 0", psel); end
    @(negedge pclk);
    tests_run++; if (resp_valid !== 4'b0 || dbg_state !== 2'd0) begin tests_failed++; $display("FAIL wr_pulse_end: got %b/%0d want 0000/0", resp_valid, dbg_state); end
    // Read it back from requester 1.
    set_req(1, 1'b0, 10'h000, 32'hFFFF_FFFF); #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL rd_ready: got %b want 0010", req_ready); end
    @(negedge pclk); req_valid[1] = 1'b0;
    tests_run++; if (pwrite !== 1'b0 || pwdata !== 32'h0) begin tests_failed++; $display("FAIL rd_setup_fields: got %b/%h want 0/0", pwrite, pwdata); end
    @(negedge pclk);
    @(negedge pclk);
    tests_run++; if (resp_valid !== 4'b0010 || resp_rdata !== 32'hC000_0123 || resp_err !== 1'b0) begin tests_failed++; $display("FAIL rd_resp: got %b/%h/%b want 0010/c0000123/0", resp_valid, resp_rdata, resp_err); end
    @(negedge pclk);
    tests_run++; if (resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL rd_rdata_clear: got %h want 0", resp_rdata); end
  endtask

  task automatic test_wait_states();
    // Requester 0 writes 0x040 while the completer stalls two extra cycles.
    @(negedge pclk); stall = 1'b1; set_req(0, 1'b1, 10'h040, 32'h1234_5678);
    @(negedge pclk); req_valid[0] = 1'b0;   // SETUP
    @(negedge pclk);                        // ACCESS, stalled
    @(negedge pclk);                        // ACCESS, stalled
    tests_run++; if ({psel, penable} !== 2'b11 || paddr !== 10'h040 || pwdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL ws_hold: got %b/%h/%h want 11/040/12345678", {psel, penable}, paddr, pwdata); end
    @(negedge pclk); stall = 1'b0;          // pready high this cycle
    tests_run++; if (resp_valid !== 4'b0) begin tests_failed++; $display("FAIL ws_early_resp: got %b want 0000", resp_valid); end
    @(negedge pclk);
    tests_run++; if (resp_valid !== 4'b0001 || resp_err !== 1'b0) begin tests_failed++; $display("FAIL ws_resp: got %b/%b want 0001/0", resp_valid, resp_err); end
  endtask

  task automatic test_contention();
    int ok;
    apply_reset();
    @(negedge pclk); set_req(0, 1'b1, 10'h010, 32'h10); set_req(2, 1'b1, 10'h020, 32'h20); #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL cont_first: got %b want 0001", req_ready); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge pclk);
      if (c == 1) req_valid[0] = 1'b0;
      #1;
      if (c == 3) begin
        tests_run++; if (resp_valid !== 4'b0001) begin tests_failed++; $display("FAIL cont_resp0: got %b want 0001", resp_valid); end
      end
      ok = (c < 4) ? (req_ready === 4'b0000) : (req_ready === 4'b0100);
      tests_run++; if (ok == 0) begin tests_failed++; $display("FAIL cont_cycle%0d_ready: got %b want %b", c, req_ready, (c < 4) ? 4'b0000 : 4'b0100); end
    end
    @(negedge pclk); req_valid[2] = 1'b0;
    repeat (3) @(negedge pclk);
    // Pointer is now 3; scanning 3 (idle) then wraps to 0 before reaching 2.
    set_req(0, 1'b1, 10'h014, 32'h14); set_req(2, 1'b1, 10'h024, 32'h24); #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL cont_wrap: got %b want 0001", req_ready); end
    @(negedge pclk); req_valid[0] = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL cont_wrap_next: got %b want 0100", req_ready); end
    @(negedge pclk); req_valid[2] = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic test_fairness();
    int grants;
    int resps;
    int cnt [N];
    int idx;
    logic [1:0] exp_id;
    apply_reset();
    for (int r = 0; r < 4; r++) for (int i = 0; i < N; i++) exp_q.push_back(2'(i));
    for (int i = 0; i < N; i++) cnt[i] = 0;
    grants = 0;
    resps  = 0;
    @(negedge pclk);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 10'(10'h080 + 4*i), 32'(i));
    for (int cyc = 0; cyc < 200 && resps < 16; cyc++) begin
      if (cyc != 0) @(negedge pclk);
      if (grants == 16) req_valid = '0;
      #1;
      for (int i = 0; i < N; i++) if (resp_valid[i]) begin cnt[i]++; resps++; end
      if (req_ready != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
        grants++;
        exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 2'd0;
        tests_run++; if (2'(idx) !== exp_id) begin tests_failed++; $display("FAIL fair_grant%0d: got %0d want %0d", grants, idx, exp_id); end
      end
    end
    tests_run++; if (grants != 16 || resps != 16) begin tests_failed++; $display("FAIL fair_total: got %0d grants/%0d resps want 16/16", grants, resps); end
    for (int i = 0; i < N; i++) begin
      tests_run++; if (cnt[i] != 4) begin tests_failed++; $display("FAIL fair_count%0d: got %0d want 4", i, cnt[i]); end
    end
    req_valid = '0;
    exp_q.delete();
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_error_align();
    apply_reset();
    // Completer error on a read of 0x300 from requester 3.
    @(negedge pclk); set_req(3, 1'b0, 10'h300, 32'h0); #1;
    tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL err_ready: got %b want 1000", req_ready); end
    @(negedge pclk); req_valid[3] = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    tests_run++; if (resp_valid !== 4'b1000 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL err_resp: got %b/%b/%h want 1000/1/0", resp_valid, resp_err, resp_rdata); end
    // Misaligned read of 0x002 from requester 2: error one cycle after grant.
    @(negedge pclk); set_req(2, 1'b0, 10'h002, 32'h0); #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL align_ready: got %b want 0100", req_ready); end
    @(negedge pclk); req_valid[2] = 1'b0;
    tests_run++; if (resp_valid !== 4'b0100 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL align_resp: got %b/%b/%h want 0100/1/0", resp_valid, resp_err, resp_rdata); end
    tests_run++; if (psel !== 1'b0) begin tests_failed++; $display("FAIL align_psel_t1: got %b want 0", psel); end
    @(negedge pclk);
    tests_run++; if (psel !== 1'b0 || resp_valid !== 4'b0) begin tests_failed++; $display("FAIL align_psel_t2: got %b/%b want 0/0000", psel, resp_valid); end
    // Misaligned write of 0x001 from requester 0.
    set_req(0, 1'b1, 10'h001, 32'hDEAD_BEEF);
    @(negedge pclk); req_valid[0] = 1'b0;
    tests_run++; if (psel !== 1'b0 || resp_valid !== 4'b0001 || resp_err !== 1'b1) begin tests_failed++; $display("FAIL align_wr: got %b/%b/%b want 0/0001/1", psel, resp_valid, resp_err); end
    @(negedge pclk);
  endtask

`ifdef LINECARD_CFG_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    @(negedge pclk); stall = 1'b1; set_req(1, 1'b0, 10'h050, 32'h0);
    @(negedge pclk); req_valid[1] = 1'b0;     // SETUP
    repeat (8) @(negedge pclk);               // eight ACCESS wait cycles
    tests_run++; if ({psel, penable} !== 2'b11) begin tests_failed++; $display("FAIL to_last_wait: got %b want 11", {psel, penable}); end
    @(negedge pclk);
    tests_run++; if (psel !== 1'b0 || resp_valid !== 4'b0010 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL to_resp: got %b/%b/%b/%h want 0/0010/1/0", psel, resp_valid, resp_err, resp_rdata); end
    stall = 1'b0;
    @(negedge pclk); set_req(1, 1'b1, 10'h054, 32'h5555_AAAA);
    @(negedge pclk); req_valid[1] = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    tests_run++; if (resp_valid !== 4'b0010 || resp_err !== 1'b0) begin tests_failed++; $display("FAIL to_after: got %b/%b want 0010/0", resp_valid, resp_err); end
    @(negedge pclk);
  endtask
`endif

  task automatic test_reset_mid_access();
    apply_reset();
    // Serve requester 2 first so the pointer moves to 3.
    @(negedge pclk); set_req(2, 1'b1, 10'h060, 32'hAA);
    @(negedge pclk); req_valid[2] = 1'b0;
    repeat (3) @(negedge pclk);
    // Requester 1 stalls in ACCESS, then reset hits.
    stall = 1'b1; set_req(1, 1'b0, 10'h060, 32'h0);
    @(negedge pclk); req_valid[1] = 1'b0;
    @(negedge pclk);
    @(negedge pclk); preset = 1'b1;
    @(negedge pclk); preset = 1'b0; stall = 1'b0; #1;
    tests_run++; if (psel !== 1'b0 || penable !== 1'b0) begin tests_failed++; $display("FAIL rma_psel: got %b/%b want 0/0", psel, penable); end
    tests_run++; if (dbg_state !== 2'd0 || resp_valid !== 4'b0) begin tests_failed++; $display("FAIL rma_state: got %0d/%b want 0/0000", dbg_state, resp_valid); end
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      tests_run++; if (resp_valid !== 4'b0) begin tests_failed++; $display("FAIL rma_no_resp%0d: got %b want 0000", c, resp_valid); end
    end
    set_req(0, 1'b1, 10'h070, 32'h70); set_req(3, 1'b1, 10'h074, 32'h74); #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL rma_ptr: got %b want 0001", req_ready); end
    @(negedge pclk); req_valid[0] = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL rma_next: got %b want 1000", req_ready); end
    @(negedge pclk); req_valid[3] = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_contention();
    test_fairness();
    test_error_align();
`ifdef LINECARD_CFG_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
